// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for a 16-bit external ALU (Ain, Bin, ALUop -> out, Z).
// Holds an 8-entry register file, decodes one instruction per handshake, stages
// shifted operands into the ALU, captures its result and writes it back with
// Z/N/V status.
// Handshake: an instruction transfers on a rising edge where instr_valid and
// instr_ready are both high; instr_ready is high only in IDLE (and never while
// reset_n is low), instr is ignored otherwise and nothing is queued.
module alu_issue_ctrl #(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] alu_ain,
  output logic [DATA_W-1:0] alu_bin,
  output logic [1:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_z,
  output logic [2:0]        status,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RDA  = 3'd1,
    S_RDB  = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_CMP = 2'b01;

  state_t state, state_next;

  logic [DATA_W-1:0] rf [8];
  logic [DATA_W-1:0] a_q, c_q, ain_q, bin_q;
  logic [1:0]        op_q, f_op, f_sh;
  logic [2:0]        f_rn, f_rd, f_rm;
  logic              f_movr;
  logic              flag_v, flag_n, flag_z;
  logic              quick_done, quick_err;

  // Instruction field decode of the word currently offered
  logic [2:0]        opc;
  logic              is_alu, is_movi, is_movr, is_ill, accept;
  logic [DATA_W-1:0] imm_sext, rm_shifted, rm_val;
  logic              ovf;

  // Shift unit applied to the second source operand
  function automatic logic [DATA_W-1:0] shift_op(input logic [DATA_W-1:0] x,
                                                 input logic [1:0] sh);
    case (sh)
      2'b01:   shift_op = {x[DATA_W-2:0], 1'b0};
      2'b10:   shift_op = {1'b0, x[DATA_W-1:1]};
      2'b11:   shift_op = {x[DATA_W-1], x[DATA_W-1:1]};
      default: shift_op = x;
    endcase
  endfunction

  // Decode, operand shaping and signed-overflow detection
  always_comb begin
    opc        = instr[15:13];
    is_alu     = (opc == 3'b101);
    is_movi    = (opc == 3'b110) && (instr[12:11] == 2'b10);
    is_movr    = (opc == 3'b110) && (instr[12:11] == 2'b00);
    is_ill     = !(is_alu || is_movi || is_movr);
    accept     = instr_valid && instr_ready;
    imm_sext   = {{(DATA_W-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};
    rm_val     = rf[f_rm];
    rm_shifted = shift_op(rm_val, f_sh);
    ovf        = 1'b0;
    if (op_q == OP_ADD)
      ovf = (ain_q[DATA_W-1] == bin_q[DATA_W-1]) && (alu_out[DATA_W-1] != ain_q[DATA_W-1]);
    else if (op_q == OP_CMP)
      ovf = (ain_q[DATA_W-1] != bin_q[DATA_W-1]) && (alu_out[DATA_W-1] != ain_q[DATA_W-1]);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state logic: only register-sourced instructions leave IDLE
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept && (is_alu || is_movr)) state_next = S_RDA;
      S_RDA:   state_next = S_RDB;
      S_RDB:   state_next = S_EXEC;
      S_EXEC:  state_next = S_WB;
      S_WB:    state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic: handshake, retire pulse and observability
  always_comb begin
    instr_ready = reset_n && (state == S_IDLE);
    done        = quick_done || (state == S_WB);
    err         = quick_err;
    alu_ain     = ain_q;
    alu_bin     = bin_q;
    alu_op      = op_q;
    status      = {flag_v, flag_n, flag_z};
    dbg_data    = rf[dbg_addr];
    dbg_state   = state;
  end

  // Datapath: field latch, operand staging, result capture, writeback.
  // ALU drive registers load on entry to EXEC so they hold between instructions.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
      a_q        <= '0;
      c_q        <= '0;
      ain_q      <= '0;
      bin_q      <= '0;
      op_q       <= OP_ADD;
      f_op       <= OP_ADD;
      f_sh       <= '0;
      f_rn       <= '0;
      f_rd       <= '0;
      f_rm       <= '0;
      f_movr     <= 1'b0;
      flag_v     <= 1'b0;
      flag_n     <= 1'b0;
      flag_z     <= 1'b0;
      quick_done <= 1'b0;
      quick_err  <= 1'b0;
    end else begin
      quick_done <= 1'b0;
      quick_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            f_op   <= instr[12:11];
            f_rn   <= instr[10:8];
            f_rd   <= instr[7:5];
            f_sh   <= instr[4:3];
            f_rm   <= instr[2:0];
            f_movr <= is_movr;
            if (is_movi) begin
              rf[instr[10:8]] <= imm_sext;
              quick_done      <= 1'b1;
            end else if (is_ill) begin
              quick_done <= 1'b1;
              quick_err  <= 1'b1;
            end
          end
        end
        S_RDA: a_q <= f_movr ? '0 : rf[f_rn];
        S_RDB: begin
          ain_q <= a_q;
          bin_q <= rm_shifted;
          op_q  <= f_movr ? OP_ADD : f_op;
        end
        S_EXEC: begin
          c_q <= alu_out;
          if (!f_movr) begin
            flag_z <= alu_z;
            flag_n <= alu_out[DATA_W-1];
            flag_v <= ovf;
          end
        end
        S_WB: begin
          if (f_movr || (f_op != OP_CMP)) rf[f_rd] <= c_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural model of the external ALU.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready, done, err;
  logic [15:0] alu_ain, alu_bin, alu_out;
  logic [1:0]  alu_op;
  logic        alu_z;
  logic [2:0]  status;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic [2:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_rf [8];
  logic [15:0] exp_q [$];

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // External ALU: ADD, SUB, AND, NOT B
  always_comb begin
    alu_out = '0;
    case (alu_op)
      2'b00: alu_out = alu_ain + alu_bin;
      2'b01: alu_out = alu_ain - alu_bin;
      2'b10: alu_out = alu_ain & alu_bin;
      2'b11: alu_out = ~alu_bin;
      default: alu_out = '0;
    endcase
    alu_z = (alu_out == 16'h0000);
  end

  alu_issue_ctrl dut (
    .clk(clk), .reset_n(reset_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .done(done), .err(err),
    .alu_ain(alu_ain), .alu_bin(alu_bin), .alu_op(alu_op),
    .alu_out(alu_out), .alu_z(alu_z), .status(status),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_state(dbg_state)
  );

  // Driver: offer one instruction once ready, then count cycles to done.
  // lat=1 means done in the cycle right after the accept edge.
  task automatic send(input logic [15:0] w, output int lat, output logic e,
                      output logic [15:0] ain, output logic [15:0] bin);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!instr_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    instr       = w;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    lat = 1;
    ain = '0;
    bin = '0;
    while (!done && lat < 12) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 3) begin
        ain = alu_ain;
        bin = alu_bin;
      end
    end
    e = err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset_n     = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    dbg_addr    = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_low: got %b want 0", instr_ready); end
    checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_done_err: got %b%b want 00", done, err); end
    checks++; if (status !== 3'b000) begin errors++; $display("FAIL rst_status: got %b want 000", status); end
    checks++; if (alu_ain !== 16'h0 || alu_bin !== 16'h0 || alu_op !== 2'b00) begin
      errors++; $display("FAIL rst_alu: got %h %h %b want 0000 0000 00", alu_ain, alu_bin, alu_op); end
    for (int i = 0; i < 8; i++) begin
      exp_rf[i] = 16'h0;
      dbg_addr = 3'(i); #1;
      checks++; if (dbg_data !== 16'h0) begin errors++; $display("FAIL rst_reg%0d: got %h want 0000", i, dbg_data); end
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_release: got %b want 1", instr_ready); end
  endtask

  task automatic test_mov_imm;
    int lat; logic e; logic [15:0] a, b;
    send(16'hD007, lat, e, a, b);
    checks++; if (lat !== 1 || e !== 1'b0) begin errors++; $display("FAIL movi_r0_lat: got lat=%0d err=%b want 1 0", lat, e); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL movi_pulse: got done=%b want 0", done); end
    send(16'hD1FE, lat, e, a, b);
    checks++; if (lat !== 1) begin errors++; $display("FAIL movi_r1_lat: got %0d want 1", lat); end
    exp_rf[0] = 16'h0007; exp_rf[1] = 16'hFFFE;
    dbg_addr = 3'd0; #1;
    checks++; if (dbg_data !== 16'h0007) begin errors++; $display("FAIL movi_r0: got %h want 0007", dbg_data); end
    dbg_addr = 3'd1; #1;
    checks++; if (dbg_data !== 16'hFFFE) begin errors++; $display("FAIL movi_r1: got %h want fffe", dbg_data); end
    checks++; if (status !== 3'b000) begin errors++; $display("FAIL movi_status: got %b want 000", status); end
  endtask

  task automatic test_add_shift;
    int lat; logic e; logic [15:0] a, b;
    send(16'hD102, lat, e, a, b);
    exp_rf[1] = 16'h0002;
    send(16'hA148, lat, e, a, b);
    exp_rf[2] = 16'h0010;
    checks++; if (lat !== 4 || e !== 1'b0) begin errors++; $display("FAIL add_lat: got lat=%0d err=%b want 4 0", lat, e); end
    checks++; if (a !== 16'h0002 || b !== 16'h000E) begin errors++; $display("FAIL add_operands: got %h %h want 0002 000e", a, b); end
    dbg_addr = 3'd2; #1;
    checks++; if (dbg_data !== 16'h0010) begin errors++; $display("FAIL add_r2: got %h want 0010", dbg_data); end
    checks++; if (status !== 3'b000) begin errors++; $display("FAIL add_status: got %b want 000", status); end
  endtask

  task automatic test_cmp;
    int lat; logic e; logic [15:0] a, b;
    send(16'hA800, lat, e, a, b);
    checks++; if (lat !== 4) begin errors++; $display("FAIL cmp_lat: got %0d want 4", lat); end
    checks++; if (status !== 3'b001) begin errors++; $display("FAIL cmp_status: got %b want 001", status); end
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i); #1;
      checks++; if (dbg_data !== exp_rf[i]) begin errors++; $display("FAIL cmp_reg%0d: got %h want %h", i, dbg_data, exp_rf[i]); end
    end
  endtask

  task automatic test_overflow;
    int lat; logic e; logic [15:0] a, b;
    send(16'hD0FF, lat, e, a, b);
    send(16'hC010, lat, e, a, b);
    exp_rf[0] = 16'h7FFF;
    checks++; if (lat !== 4) begin errors++; $display("FAIL movr_lat: got %0d want 4", lat); end
    dbg_addr = 3'd0; #1;
    checks++; if (dbg_data !== 16'h7FFF) begin errors++; $display("FAIL movr_lsr_r0: got %h want 7fff", dbg_data); end
    checks++; if (status !== 3'b001) begin errors++; $display("FAIL movr_keeps_status: got %b want 001", status); end
    send(16'hD101, lat, e, a, b);
    exp_rf[1] = 16'h0001;
    send(16'hA061, lat, e, a, b);
    exp_rf[3] = 16'h8000;
    dbg_addr = 3'd3; #1;
    checks++; if (dbg_data !== 16'h8000) begin errors++; $display("FAIL ovf_r3: got %h want 8000", dbg_data); end
    checks++; if (status !== 3'b110) begin errors++; $display("FAIL ovf_status: got %b want 110", status); end
  endtask

  task automatic test_mvn_shift;
    int lat; logic e; logic [15:0] a, b;
    send(16'hC083, lat, e, a, b);
    exp_rf[4] = 16'h8000;
    dbg_addr = 3'd4; #1;
    checks++; if (dbg_data !== 16'h8000) begin errors++; $display("FAIL movr_r4: got %h want 8000", dbg_data); end
    send(16'hB8BC, lat, e, a, b);
    exp_rf[5] = 16'h3FFF;
    checks++; if (a !== 16'h7FFF || b !== 16'hC000) begin errors++; $display("FAIL mvn_operands: got %h %h want 7fff c000", a, b); end
    dbg_addr = 3'd5; #1;
    checks++; if (dbg_data !== 16'h3FFF) begin errors++; $display("FAIL mvn_r5: got %h want 3fff", dbg_data); end
    checks++; if (status !== 3'b000) begin errors++; $display("FAIL mvn_status: got %b want 000", status); end
    send(16'hC0D4, lat, e, a, b);
    exp_rf[6] = 16'h4000;
    checks++; if (a !== 16'h0000 || b !== 16'h4000) begin errors++; $display("FAIL movr_lsr_operands: got %h %h want 0000 4000", a, b); end
    dbg_addr = 3'd6; #1;
    checks++; if (dbg_data !== 16'h4000) begin errors++; $display("FAIL movr_r6: got %h want 4000", dbg_data); end
    checks++; if (alu_op !== 2'b00 || alu_bin !== 16'h4000) begin errors++; $display("FAIL alu_hold: got %b %h want 00 4000", alu_op, alu_bin); end
  endtask

  task automatic test_reset_mid;
    int seen;
    int guard;
    guard = 0;
    @(negedge clk);
    while (!instr_ready && guard < 20) begin @(negedge clk); guard++; end
    instr = 16'hA148; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || instr_ready !== 1'b0) begin errors++; $display("FAIL rstmid_in_reset: got done=%b ready=%b want 0 0", done, instr_ready); end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", instr_ready); end
    checks++; if (status !== 3'b000 || alu_ain !== 16'h0 || alu_bin !== 16'h0 || alu_op !== 2'b00) begin
      errors++; $display("FAIL rstmid_cleared: got %b %h %h %b want 000 0000 0000 00", status, alu_ain, alu_bin, alu_op); end
    for (int i = 0; i < 8; i++) begin
      exp_rf[i] = 16'h0;
      dbg_addr = 3'(i); #1;
      checks++; if (dbg_data !== 16'h0) begin errors++; $display("FAIL rstmid_reg%0d: got %h want 0000", i, dbg_data); end
    end
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses want 0", seen); end
  endtask

  task automatic test_illegal;
    int lat; logic e; logic [15:0] a, b;
    send(16'hD007, lat, e, a, b);
    exp_rf[0] = 16'h0007;
    send(16'hE000, lat, e, a, b);
    checks++; if (lat !== 1 || e !== 1'b1) begin errors++; $display("FAIL ill_e000: got lat=%0d err=%b want 1 1", lat, e); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ill_err_pulse: got %b want 0", err); end
    send(16'hC8FF, lat, e, a, b);
    checks++; if (lat !== 1 || e !== 1'b1) begin errors++; $display("FAIL ill_c8ff: got lat=%0d err=%b want 1 1", lat, e); end
    checks++; if (status !== 3'b000) begin errors++; $display("FAIL ill_status: got %b want 000", status); end
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i); #1;
      checks++; if (dbg_data !== exp_rf[i]) begin errors++; $display("FAIL ill_reg%0d: got %h want %h", i, dbg_data, exp_rf[i]); end
    end
  endtask

  task automatic test_back_to_back;
    int lat; logic e; logic [15:0] a, b;
    int acc_n, done_n;
    logic pend, acc;
    logic [15:0] r7, want;
    send(16'hD103, lat, e, a, b);
    exp_rf[1] = 16'h0003;
    acc_n = 0; done_n = 0; pend = 1'b0; r7 = 16'h0;
    dbg_addr = 3'd7;
    for (int cyc = 0; cyc < 19; cyc++) begin
      @(negedge clk);
      instr       = 16'hA7E1;
      instr_valid = (cyc < 15);
      acc         = instr_valid && instr_ready;
      @(posedge clk); #1;
      if (acc) begin
        acc_n++;
        r7 = r7 + 16'h0003;
        exp_q.push_back(r7);
      end
      if (pend) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra_retire: got r7=%h with nothing pending", dbg_data);
        end else begin
          want = exp_q.pop_front();
          if (dbg_data !== want) begin errors++; $display("FAIL b2b_r7: got %h want %h", dbg_data, want); end
        end
      end
      pend = done;
      if (done) done_n++;
    end
    instr_valid = 1'b0;
    checks++; if (acc_n !== 3 || done_n !== 3) begin errors++; $display("FAIL b2b_counts: got acc=%0d done=%0d want 3 3", acc_n, done_n); end
    checks++; if (dbg_data !== 16'h0009) begin errors++; $display("FAIL b2b_final_r7: got %h want 0009", dbg_data); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_unretired: got %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_mov_imm();
    test_add_shift();
    test_cmp();
    test_overflow();
    test_mvn_shift();
    test_reset_mid();
    test_illegal();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
